// File: rtl/melody_player.sv
// Seven-note buzzer melody player with per-note octave/duty and optional looping.
// Optional pause input is compiled in when MELODY_PLAYER_PAUSE_EN is defined.
module melody_player #(
    parameter int          NOTE_LEN = 25000000,
    parameter int          GAP_LEN  = 2500000,
    parameter int          SONG_LEN = 8,
    parameter logic [17:0] DO       = 18'd190839,
    parameter logic [17:0] RE       = 18'd170067,
    parameter logic [17:0] MI       = 18'd151514,
    parameter logic [17:0] FA       = 18'd143265,
    parameter logic [17:0] SO       = 18'd127550,
    parameter logic [17:0] LA       = 18'd113635,
    parameter logic [17:0] XI       = 18'd101214
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [1:0] octave,
    input  logic [1:0] duty_sel,
`ifdef MELODY_PLAYER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       beep,
    output logic       busy,
    output logic       done,
    output logic [2:0] note_idx
);

    localparam int NW = $clog2(NOTE_LEN + 1);
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam int GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
    localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_LEN - 1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_LAST);
    localparam logic [2:0] LAST_IDX = 3'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   note_cnt_q, note_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [17:0]     freq_cnt_q, freq_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      oct_q, oct_d;
    logic [1:0]      duty_q, duty_d;
    logic            beep_q, beep_d;
    logic            done_q, done_d;

    logic            paused;
    logic            advance;
    logic            begin_note;
    logic [17:0]     tone;
    logic [17:0]     period;
    logic [18:0]     period_p1;
    logic [18:0]     hi;
    logic            is_rest;

`ifdef MELODY_PLAYER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Entry 7 is a rest: zero tone, beep gated off below.
    always_comb begin
        case (idx_q)
            3'd0:    tone = DO;
            3'd1:    tone = RE;
            3'd2:    tone = MI;
            3'd3:    tone = FA;
            3'd4:    tone = SO;
            3'd5:    tone = LA;
            3'd6:    tone = XI;
            default: tone = '0;
        endcase
    end

    assign is_rest   = (idx_q == 3'd7);
    assign period    = tone >> oct_q;
    assign period_p1 = {1'b0, period} + 19'd1;
    assign hi        = period_p1 >> ({1'b0, duty_q} + 3'd1);

    always_comb begin
        state_d    = state_q;
        note_cnt_d = note_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        freq_cnt_d = freq_cnt_q;
        idx_d      = idx_q;
        oct_d      = oct_q;
        duty_d     = duty_q;
        done_d     = 1'b0;
        advance    = 1'b0;
        begin_note = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = PLAY;
                    idx_d      = 3'd0;
                    begin_note = 1'b1;
                end
            end
            PLAY: begin
                if (!stop && !paused) begin
                    if (freq_cnt_q >= period) begin
                        freq_cnt_d = '0;
                    end else begin
                        freq_cnt_d = freq_cnt_q + 18'd1;
                    end
                    if (note_cnt_q == NOTE_LAST) begin
                        note_cnt_d = '0;
                        if (GAP_LEN > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        note_cnt_d = note_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!stop && !paused) begin
                    if (gap_cnt_q == GAP_END) begin
                        gap_cnt_d = '0;
                        advance   = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // loop_en only matters at this point, the end of the last entry.
        if (advance) begin
            if (idx_q != LAST_IDX) begin
                state_d    = PLAY;
                idx_d      = idx_q + 3'd1;
                begin_note = 1'b1;
            end else if (loop_en) begin
                state_d    = PLAY;
                idx_d      = 3'd0;
                begin_note = 1'b1;
            end else begin
                state_d    = IDLE;
                idx_d      = 3'd0;
                freq_cnt_d = '0;
                done_d     = 1'b1;
            end
        end

        if (begin_note) begin
            note_cnt_d = '0;
            freq_cnt_d = '0;
            oct_d      = octave;
            duty_d     = duty_sel;
        end

        if (stop && state_q != IDLE) begin
            state_d    = IDLE;
            idx_d      = 3'd0;
            note_cnt_d = '0;
            gap_cnt_d  = '0;
            freq_cnt_d = '0;
            done_d     = 1'b0;
        end
    end

    // Looking at state_d keeps beep low on the first gap cycle.
    assign beep_d = (state_q == PLAY) && (state_d == PLAY) && !paused
                    && !is_rest && ({1'b0, freq_cnt_q} < hi);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            note_cnt_q <= '0;
            gap_cnt_q  <= '0;
            freq_cnt_q <= '0;
            idx_q      <= '0;
            oct_q      <= '0;
            duty_q     <= '0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_cnt_q <= note_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            freq_cnt_q <= freq_cnt_d;
            idx_q      <= idx_d;
            oct_q      <= oct_d;
            duty_q     <= duty_d;
            beep_q     <= beep_d;
            done_q     <= done_d;
        end
    end

    assign beep     = beep_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with shortened note/gap lengths and small tones.
// Pause scenario is compiled when MELODY_PLAYER_PAUSE_EN is defined.
module tb_melody_player;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] octave = 2'd0;
    logic [1:0] duty_sel = 2'd0;
    logic       pause = 1'b0;
    logic       beep;
    logic       busy;
    logic       done;
    logic [2:0] note_idx;

    int checks = 0;
    int failures = 0;
    int t = 0;

    melody_player #(
        .NOTE_LEN(200), .GAP_LEN(20), .SONG_LEN(8),
        .DO(18'd9), .RE(18'd7), .MI(18'd5), .FA(18'd3),
        .SO(18'd11), .LA(18'd15), .XI(18'd19)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .octave(octave),
        .duty_sel(duty_sel),
`ifdef MELODY_PLAYER_PAUSE_EN
        .pause(pause),
`endif
        .beep(beep),
        .busy(busy),
        .done(done),
        .note_idx(note_idx)
    );

    always #5 sys_clk = ~sys_clk;

    // t=0 is the negedge right after the edge that captured start.
    task automatic do_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        t = 0;
    endtask

    task automatic do_stop();
        @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
    endtask

    task automatic adv(input int target);
        while (t < target) begin
            @(negedge sys_clk);
            t++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({beep, busy, done, note_idx} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=000000",
                     {beep, busy, done, note_idx});
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b want=0", busy);
        end
    endtask

    task automatic test_song();
        int done_n = 0;
        int done_t = -1;
        int gap_hi = 0;
        int rest_hi = 0;
        logic exp_b;
        loop_en = 1'b0;
        octave = 2'd0;
        duty_sel = 2'd0;
        do_start();
        checks++;
        if ({busy, note_idx, beep} !== 5'b1_000_0) begin
            failures++;
            $display("FAIL start_latency busy/idx/beep=%b want=10000",
                     {busy, note_idx, beep});
        end
        for (int j = 1; j <= 20; j++) begin
            @(negedge sys_clk);
            t++;
            exp_b = ((j - 1) % 10) < 5;
            checks++;
            if (beep !== exp_b) begin
                failures++;
                $display("FAIL do_beep t=%0d got=%b want=%b", t, beep, exp_b);
            end
        end
        while (t < 1765) begin
            @(negedge sys_clk);
            t++;
            if (t < 1760 && (t % 220) == 100) begin
                checks++;
                if (note_idx !== 3'(t / 220)) begin
                    failures++;
                    $display("FAIL note_idx t=%0d got=%0d want=%0d",
                             t, note_idx, t / 220);
                end
            end
            if (t == 221 || t == 224) begin
                checks++;
                if (beep !== 1'b1) begin
                    failures++;
                    $display("FAIL re_beep_hi t=%0d got=%b want=1", t, beep);
                end
            end
            if (t == 225) begin
                checks++;
                if (beep !== 1'b0) begin
                    failures++;
                    $display("FAIL re_beep_lo t=%0d got=%b want=0", t, beep);
                end
            end
            if (t < 1760 && (t % 220) >= 201 && beep) gap_hi++;
            if (t >= 1541 && t <= 1740 && beep) rest_hi++;
            if (done) begin
                done_n++;
                done_t = t;
            end
        end
        checks++;
        if (gap_hi !== 0) begin
            failures++;
            $display("FAIL gap_beep got=%0d high cycles want=0", gap_hi);
        end
        checks++;
        if (rest_hi !== 0) begin
            failures++;
            $display("FAIL rest_beep got=%0d high cycles want=0", rest_hi);
        end
        checks++;
        if (done_n !== 1 || done_t !== 1760) begin
            failures++;
            $display("FAIL done_pulse count=%0d at=%0d want=1 at 1760",
                     done_n, done_t);
        end
        checks++;
        if (busy !== 1'b0 || note_idx !== 3'd0) begin
            failures++;
            $display("FAIL song_end busy=%b idx=%0d want=0 0", busy, note_idx);
        end
    endtask

    task automatic test_duty_octave();
        logic exp_b;
        duty_sel = 2'd1;
        octave = 2'd0;
        do_start();
        adv(1100);
        for (int j = 1; j <= 64; j++) begin
            @(negedge sys_clk);
            t++;
            exp_b = ((j - 1) % 16) < 4;
            checks++;
            if (beep !== exp_b) begin
                failures++;
                $display("FAIL la_duty t=%0d got=%b want=%b", t, beep, exp_b);
            end
            if (j == 32) duty_sel = 2'd0;
        end
        do_stop();
        checks++;
        if (busy !== 1'b0 || beep !== 1'b0) begin
            failures++;
            $display("FAIL stop1 busy/beep=%b%b want=00", busy, beep);
        end
        duty_sel = 2'd1;
        octave = 2'd1;
        do_start();
        adv(1100);
        for (int j = 1; j <= 32; j++) begin
            @(negedge sys_clk);
            t++;
            exp_b = ((j - 1) % 8) < 2;
            checks++;
            if (beep !== exp_b) begin
                failures++;
                $display("FAIL la_octave t=%0d got=%b want=%b", t, beep, exp_b);
            end
        end
        do_stop();
        duty_sel = 2'd0;
        octave = 2'd0;
    endtask

    task automatic test_loop_stop();
        int done_n = 0;
        loop_en = 1'b1;
        do_start();
        adv(1759);
        checks++;
        if (note_idx !== 3'd7) begin
            failures++;
            $display("FAIL loop_last idx=%0d want=7", note_idx);
        end
        adv(1760);
        checks++;
        if (note_idx !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL loop_wrap idx=%0d busy=%b done=%b want=0 1 0",
                     note_idx, busy, done);
        end
        adv(1761);
        checks++;
        if (beep !== 1'b1) begin
            failures++;
            $display("FAIL loop_beep got=%b want=1", beep);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge sys_clk);
            if (done) done_n++;
        end
        checks++;
        if (done_n !== 0) begin
            failures++;
            $display("FAIL loop_done got=%0d pulses want=0", done_n);
        end
        do_stop();
        checks++;
        if ({busy, beep, done, note_idx} !== 6'b0) begin
            failures++;
            $display("FAIL loop_stop got=%b want=000000",
                     {busy, beep, done, note_idx});
        end
        loop_en = 1'b0;
    endtask

    task automatic test_start_stop();
        @(negedge sys_clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle busy=%b want=0", busy);
        end
        do_start();
        adv(50);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        t = t + 2;
        adv(219);
        checks++;
        if (note_idx !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_ignored t=219 idx=%0d busy=%b want=0 1",
                     note_idx, busy);
        end
        adv(220);
        checks++;
        if (note_idx !== 3'd1) begin
            failures++;
            $display("FAIL restart_timing t=220 idx=%0d want=1", note_idx);
        end
        @(negedge sys_clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || note_idx !== 3'd0) begin
            failures++;
            $display("FAIL start_stop_busy busy=%b idx=%0d want=0 0",
                     busy, note_idx);
        end
    endtask

    task automatic test_async_reset();
        int act = 0;
        do_start();
        adv(103);
        checks++;
        if (beep !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_beep got=%b want=1", beep);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({beep, busy, done, note_idx} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b want=000000",
                     {beep, busy, done, note_idx});
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge sys_clk);
            if (busy || beep || done) act++;
        end
        checks++;
        if (act !== 0) begin
            failures++;
            $display("FAIL post_reset_activity got=%0d cycles want=0", act);
        end
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_after_reset busy=%b want=1", busy);
        end
        do_stop();
    endtask

`ifdef MELODY_PLAYER_PAUSE_EN
    task automatic test_pause();
        int bad = 0;
        do_start();
        adv(490);
        pause = 1'b1;
        for (int j = 0; j < 50; j++) begin
            @(negedge sys_clk);
            t++;
            if (beep !== 1'b0 || busy !== 1'b1 || note_idx !== 3'd2) bad++;
        end
        pause = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL pause_hold got=%0d bad cycles want=0", bad);
        end
        adv(709);
        checks++;
        if (note_idx !== 3'd2) begin
            failures++;
            $display("FAIL pause_end t=709 idx=%0d want=2", note_idx);
        end
        adv(710);
        checks++;
        if (note_idx !== 3'd3) begin
            failures++;
            $display("FAIL pause_next t=710 idx=%0d want=3", note_idx);
        end
        do_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_song();
        test_duty_octave();
        test_loop_stop();
        test_start_stop();
        test_async_reset();
`ifdef MELODY_PLAYER_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter NOTE_LEN, default 25000000, means sys_clk cycles per note (minimum 2).
REQ-002 Parameter GAP_LEN, default 2500000, means silent sys_clk cycles after each note; 0 means no gap.
REQ-003 Parameter SONG_LEN, default 8, means table entries played (range 1..8).
REQ-004 Parameters DO, RE, MI, FA, SO, LA, XI are 18-bit tone terminal counts: DO=190839, RE=170067, MI=151514, FA=143265, SO=127550, LA=113635, XI=101214.
REQ-005 sys_clk  input  1  system clock, 50 MHz.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins playback from entry 0.
REQ-008 stop  input  1  one-cycle pulse that aborts playback.
REQ-009 loop_en  input  1  when 1, the song restarts at entry 0 after the last entry.
REQ-010 octave  input  2  tone terminal count is right-shifted by octave (0..3).
REQ-011 duty_sel  input  2  high-time fraction: 0=1/2, 1=1/4, 2=1/8, 3=1/16.
REQ-012 beep  output  1  buzzer drive.
REQ-013 busy  output  1  high while not IDLE.
REQ-014 done  output  1  one-cycle pulse when a non-looping song completes.
REQ-015 note_idx  output  3  index of the entry currently playing.

Function
REQ-016 The fixed song table SHALL be: entries 0..6 = DO, RE, MI, FA, SO, LA, XI; entry 7 = rest.
REQ-017 The FSM states SHALL be IDLE, PLAY and GAP.
- IDLE->PLAY on start with stop low.
- PLAY->GAP after NOTE_LEN cycles.
- GAP->PLAY at the next index after GAP_LEN cycles.
- With GAP_LEN=0, PLAY goes directly to the next PLAY.
REQ-018 After the last entry (index SONG_LEN-1), the block SHALL go to PLAY at index 0 if loop_en=1; otherwise it SHALL go to IDLE and pulse done for exactly that cycle.
REQ-019 loop_en SHALL be sampled at the end of the last entry.
REQ-020 octave and duty_sel SHALL be latched at each note start and held for that note.
REQ-021 The period count P SHALL be tone>>octave, with a tone period of P+1 cycles; freq_cnt (18 bits) counts 0..P and SHALL be cleared at every note start.
REQ-022 The duty threshold SHALL be H=(P+1)>>(duty_sel+1).
- beep is registered: 1 when in PLAY, the entry is not a rest and freq_cnt<H; else 0.
- If H=0, beep stays 0.
REQ-023 beep SHALL be 0 in IDLE, in GAP and during rest entries.
REQ-024 Latency: with start at clock edge t, busy=1 and note_idx=0 after edge t+1, and beep first goes 1 after edge t+2.
REQ-025 start while busy SHALL be ignored.
REQ-026 stop in PLAY or GAP SHALL force IDLE at the next edge: beep=0, busy=0, note_idx=0, no done pulse.
REQ-027 start and stop asserted together SHALL leave the block in or return it to IDLE, because stop wins.
REQ-028 The note-length counter width SHALL be $clog2(NOTE_LEN+1), and the gap counter width SHALL be $clog2(GAP_LEN+1) with a minimum of 1.

Reset
REQ-029 Asserting sys_rst_n low SHALL asynchronously force IDLE: beep=0, busy=0, done=0, note_idx=0, all counters 0.
REQ-030 Reset mid-song SHALL abort playback without a done pulse; after release, playback requires a new start.

Configuration
REQ-031 With macro MELODY_PLAYER_PAUSE_EN defined, the block SHALL add input port pause (1 bit).
- While pause=1 in PLAY or GAP: all counters and note_idx freeze, beep is 0, busy stays 1.
- Releasing pause resumes from the frozen counts.
- stop overrides pause.
REQ-032 Without MELODY_PLAYER_PAUSE_EN, the pause port and all its logic SHALL be absent and behaviour is as above.

Verification
REQ-033 Bench parameters: NOTE_LEN=200, GAP_LEN=20, SONG_LEN=8, DO=9, RE=7, MI=5, FA=3, SO=11, LA=15, XI=19.
REQ-034 Scenario 1: start, loop_en=0, octave=0, duty_sel=0 -> during DO, beep is 5 cycles high then 5 low repeating; note_idx steps 0..7 every 220 cycles; done pulses once 1760 cycles after busy rises; then busy=0.
REQ-035 Scenario 2: duty_sel=1 on the LA note -> beep is 4 high then 12 low per 16 cycles; octave=1 on LA -> P=7, so 2 high then 6 low.
REQ-036 Scenario 3: loop_en=1 -> after index 7, note_idx returns to 0 with no done pulse; then stop -> busy=0 and beep=0 the next cycle.
REQ-037 Scenario 4: start and stop in the same cycle, and start while busy -> no state change in either case.
REQ-038 Scenario 5: sys_rst_n low mid-note for 3 cycles -> immediately beep=0, busy=0, note_idx=0; no activity until the next start.
REQ-039 Scenario 6 (with MELODY_PLAYER_PAUSE_EN): pause for 50 cycles in note 2 -> beep is 0 during the pause, and note 2 ends 50 cycles later than without the pause.
